// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle sequencing controller for an external combinational ALU.
// Fetches a 32-bit instruction, decodes it into the ALU's ALUFUNC/ALUR
// encoding, registers the operands onto ALU_A/ALU_B and then uses ALUOUT/Z
// for register writeback, data-memory access, branches and JAL.
//
// Instruction fields:
//   OP=IR[31:27] RD=IR[26:23] RS=IR[22:19] RT=IR[18:15] FN=IR[4:0]
//   IMM = sign-extended IR[14:0]
//
// Optional feature macro: ALU_SEQ_CTRL_TRAP_EN
//   defined     : illegal OP/FN enters TRAP (ILLEGAL=1, PC frozen, no REQ/WE),
//                 left only through RESET.
//   not defined : illegal instructions retire as a 2-cycle NOP, ILLEGAL=0.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   IMEM_ADDR/REQ/RDY/DATA instruction fetch port (IMEM_ADDR = PC)
//   RS_ADDR, RT_ADDR      register-file read addresses (combinational from IR)
//   RS_DATA, RT_DATA      register-file read data
//   ALUFUNC, ALUR         registered ALU function select
//   ALU_A, ALU_B          registered ALU operands
//   ALUOUT, Z             ALU result and zero/condition flag
//   REG_WE/WADDR/WDATA    register-file write port (WE is a one-cycle pulse)
//   DMEM_REQ/WE/ADDR/WDATA/RDY/RDATA  data-memory port
//   ILLEGAL               sticky illegal-instruction flag
//   DBG_STATE             current FSM state: 0 FETCH, 1 DECODE, 2 EXEC,
//                         3 MEM, 4 WB, 5 TRAP
//
// Memory handshake (both IMEM and DMEM): REQ is a valid. Once raised, REQ
// stays high with address/write data unchanged until the cycle in which RDY
// is high; the transfer completes on that rising edge. RDY is ignored while
// REQ is low.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int               DBITS      = 32,
    parameter int               OPCODEBITS = 5,
    parameter logic [DBITS-1:0] RESETPC    = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [DBITS-1:0]      IMEM_ADDR,
    output logic                  IMEM_REQ,
    input  logic                  IMEM_RDY,
    input  logic [31:0]           IMEM_DATA,
    output logic [3:0]            RS_ADDR,
    output logic [3:0]            RT_ADDR,
    input  logic [DBITS-1:0]      RS_DATA,
    input  logic [DBITS-1:0]      RT_DATA,
    output logic [OPCODEBITS-1:0] ALUFUNC,
    output logic                  ALUR,
    output logic [DBITS-1:0]      ALU_A,
    output logic [DBITS-1:0]      ALU_B,
    input  logic [DBITS-1:0]      ALUOUT,
    input  logic                  Z,
    output logic                  REG_WE,
    output logic [3:0]            REG_WADDR,
    output logic [DBITS-1:0]      REG_WDATA,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic [DBITS-1:0]      DMEM_ADDR,
    output logic [DBITS-1:0]      DMEM_WDATA,
    input  logic                  DMEM_RDY,
    input  logic [DBITS-1:0]      DMEM_RDATA,
    output logic                  ILLEGAL,
    output logic [2:0]            DBG_STATE
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Register-class function codes (OP = 00000)
    localparam logic [4:0] FN_ADD  = 5'b11000;
    localparam logic [4:0] FN_SUB  = 5'b01000;
    localparam logic [4:0] FN_AND  = 5'b11100;
    localparam logic [4:0] FN_OR   = 5'b11101;
    localparam logic [4:0] FN_XOR  = 5'b11110;
    localparam logic [4:0] FN_NAND = 5'b01100;
    localparam logic [4:0] FN_NOR  = 5'b01101;
    localparam logic [4:0] FN_NXOR = 5'b01110;
    localparam logic [4:0] FN_EQ   = 5'b10000;
    localparam logic [4:0] FN_LT   = 5'b10001;
    localparam logic [4:0] FN_LE   = 5'b10010;
    localparam logic [4:0] FN_NE   = 5'b10011;

    // Primary opcodes
    localparam logic [4:0] OP_RCLASS = 5'b00000;
    localparam logic [4:0] OP_ADDI   = 5'b11000;
    localparam logic [4:0] OP_ANDI   = 5'b11100;
    localparam logic [4:0] OP_ORI    = 5'b11101;
    localparam logic [4:0] OP_XORI   = 5'b11110;
    localparam logic [4:0] OP_LW     = 5'b01010;
    localparam logic [4:0] OP_SW     = 5'b01110;
    localparam logic [4:0] OP_BEQ    = 5'b10000;
    localparam logic [4:0] OP_BLT    = 5'b10001;
    localparam logic [4:0] OP_BLE    = 5'b10010;
    localparam logic [4:0] OP_BNE    = 5'b10011;
    localparam logic [4:0] OP_JAL    = 5'b10111;

    state_t state, next_state;

    logic [DBITS-1:0] pc;
    logic [31:0]      ir;
    logic [DBITS-1:0] alu_a_r, alu_b_r;
    logic [OPCODEBITS-1:0] alufunc_r;
    logic             alur_r;
    logic [3:0]       reg_waddr_r;
    logic [DBITS-1:0] reg_wdata_r;
    logic [DBITS-1:0] dmem_addr_r, dmem_wdata_r;

    // ------------------------------------------------------------------
    // Instruction field extraction and classification (from IR)
    // ------------------------------------------------------------------
    logic [4:0]       op, fn;
    logic [3:0]       rd;
    logic [DBITS-1:0] imm, imm_x4, pc_plus4;
    logic             is_rclass, rfn_legal, is_alui, is_lw, is_sw;
    logic             is_br, is_jal, legal;

    assign op       = ir[31:27];
    assign rd       = ir[26:23];
    assign fn       = ir[4:0];
    assign imm      = {{(DBITS-15){ir[14]}}, ir[14:0]};
    assign imm_x4   = imm << 2;
    assign pc_plus4 = pc + DBITS'(4);

    always_comb begin
        rfn_legal = 1'b0;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NAND,
            FN_NOR, FN_NXOR, FN_EQ, FN_LT, FN_LE, FN_NE: rfn_legal = 1'b1;
            default:                                     rfn_legal = 1'b0;
        endcase
    end

    assign is_rclass = (op == OP_RCLASS);
    assign is_alui   = (op == OP_ADDI) || (op == OP_ANDI) ||
                       (op == OP_ORI)  || (op == OP_XORI);
    assign is_lw     = (op == OP_LW);
    assign is_sw     = (op == OP_SW);
    assign is_br     = (op == OP_BEQ) || (op == OP_BLT) ||
                       (op == OP_BLE) || (op == OP_BNE);
    assign is_jal    = (op == OP_JAL);
    assign legal     = is_rclass ? rfn_legal
                                 : (is_alui || is_lw || is_sw || is_br || is_jal);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH: begin
                if (IMEM_RDY) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (legal) begin
                    next_state = S_EXEC;
                end else begin
`ifdef ALU_SEQ_CTRL_TRAP_EN
                    next_state = S_TRAP;
`else
                    next_state = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw)      next_state = S_MEM;
                else if (is_br || is_jal) next_state = S_FETCH;
                else                     next_state = S_WB;
            end
            S_MEM: begin
                if (DMEM_RDY) next_state = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        IMEM_REQ  = 1'b0;
        REG_WE    = 1'b0;
        DMEM_REQ  = 1'b0;
        DMEM_WE   = 1'b0;
        DBG_STATE = state;
        unique case (state)
            // No fetch is issued while reset is held, even though the
            // state register already sits in FETCH.
            S_FETCH:  IMEM_REQ = ~RESET;
            // JAL writes its link register in EXEC; the link value was
            // staged into REG_WDATA during DECODE.
            S_EXEC:   REG_WE   = is_jal;
            S_MEM: begin
                DMEM_REQ = 1'b1;
                DMEM_WE  = is_sw;
            end
            S_WB:     REG_WE   = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc           <= RESETPC;
            ir           <= '0;
            alufunc_r    <= '0;
            alur_r       <= 1'b0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            reg_waddr_r  <= '0;
            reg_wdata_r  <= '0;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (IMEM_RDY) ir <= IMEM_DATA;
                end
                S_DECODE: begin
                    alur_r      <= is_rclass;
                    alufunc_r   <= is_rclass ? OPCODEBITS'(fn) : OPCODEBITS'(op);
                    // Branch operands are swapped so that Z reports RS op RT.
                    alu_a_r     <= is_br ? RT_DATA : RS_DATA;
                    if (is_rclass)   alu_b_r <= RT_DATA;
                    else if (is_br)  alu_b_r <= RS_DATA;
                    else if (is_jal) alu_b_r <= imm_x4;
                    else             alu_b_r <= imm;
                    reg_waddr_r <= rd;
                    if (is_sw)  dmem_wdata_r <= RT_DATA;
                    if (is_jal) reg_wdata_r  <= pc_plus4;
`ifndef ALU_SEQ_CTRL_TRAP_EN
                    // Illegal instruction retires as a NOP.
                    if (!legal) pc <= pc_plus4;
`endif
                end
                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        dmem_addr_r <= ALUOUT;
                    end else if (is_br) begin
                        pc <= Z ? (pc_plus4 + imm_x4) : pc_plus4;
                    end else if (is_jal) begin
                        pc <= ALUOUT;
                    end else begin
                        reg_wdata_r <= ALUOUT;
                    end
                end
                S_MEM: begin
                    if (DMEM_RDY) begin
                        if (is_sw) pc          <= pc_plus4;
                        else       reg_wdata_r <= DMEM_RDATA;
                    end
                end
                S_WB:    pc <= pc_plus4;
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_CTRL_TRAP_EN
    logic illegal_r;

    // Set on the DECODE edge that detects the fault; cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            illegal_r <= 1'b0;
        end else if (state == S_DECODE && !legal) begin
            illegal_r <= 1'b1;
        end
    end

    assign ILLEGAL = illegal_r;
`else
    assign ILLEGAL = 1'b0;
`endif

    assign IMEM_ADDR  = pc;
    assign RS_ADDR    = ir[22:19];
    assign RT_ADDR    = ir[18:15];
    assign ALUFUNC    = alufunc_r;
    assign ALUR       = alur_r;
    assign ALU_A      = alu_a_r;
    assign ALU_B      = alu_b_r;
    assign REG_WADDR  = reg_waddr_r;
    assign REG_WDATA  = reg_wdata_r;
    assign DMEM_ADDR  = dmem_addr_r;
    assign DMEM_WDATA = dmem_wdata_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Drives alu_seq_ctrl with a behavioural ALU, instruction memory and data
// memory. Instruction vectors live in a table; expected register writes are
// queued when an instruction is issued and popped when REG_WE fires.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    localparam int DBITS = 32;
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_TRAP  = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DBITS-1:0] imem_addr;
    logic             imem_req, imem_rdy;
    logic [31:0]      imem_data;
    logic [3:0]       rs_addr, rt_addr;
    logic [DBITS-1:0] rs_data, rt_data;
    logic [4:0]       alufunc;
    logic             alur;
    logic [DBITS-1:0] alu_a, alu_b, aluout;
    logic             z;
    logic             reg_we;
    logic [3:0]       reg_waddr;
    logic [DBITS-1:0] reg_wdata;
    logic             dmem_req, dmem_we, dmem_rdy;
    logic [DBITS-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic             illegal;
    logic [2:0]       dbg_state;

    alu_seq_ctrl #(.DBITS(DBITS), .OPCODEBITS(5), .RESETPC(32'h0)) dut (
        .CLK(clk), .RESET(reset),
        .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req), .IMEM_RDY(imem_rdy),
        .IMEM_DATA(imem_data),
        .RS_ADDR(rs_addr), .RT_ADDR(rt_addr), .RS_DATA(rs_data), .RT_DATA(rt_data),
        .ALUFUNC(alufunc), .ALUR(alur), .ALU_A(alu_a), .ALU_B(alu_b),
        .ALUOUT(aluout), .Z(z),
        .REG_WE(reg_we), .REG_WADDR(reg_waddr), .REG_WDATA(reg_wdata),
        .DMEM_REQ(dmem_req), .DMEM_WE(dmem_we), .DMEM_ADDR(dmem_addr),
        .DMEM_WDATA(dmem_wdata), .DMEM_RDY(dmem_rdy), .DMEM_RDATA(dmem_rdata),
        .ILLEGAL(illegal), .DBG_STATE(dbg_state)
    );

    // ---------------- behavioural ALU ----------------
    // Compares evaluate B op A, so branches (A=RT, B=RS) see RS op RT.
    always_comb begin
        aluout = '0;
        case (alufunc)
            5'b11000: aluout = alu_a + alu_b;
            5'b01000: aluout = alu_a - alu_b;
            5'b11100: aluout = alu_a & alu_b;
            5'b11101: aluout = alu_a | alu_b;
            5'b11110: aluout = alu_a ^ alu_b;
            5'b01100: aluout = ~(alu_a & alu_b);
            5'b01101: aluout = ~(alu_a | alu_b);
            5'b01110: aluout = alur ? ~(alu_a ^ alu_b) : (alu_a + alu_b);
            5'b01010: aluout = alu_a + alu_b;
            5'b10111: aluout = alu_a + alu_b;
            5'b10000: aluout = {31'b0, alu_b == alu_a};
            5'b10001: aluout = {31'b0, $signed(alu_b) <  $signed(alu_a)};
            5'b10010: aluout = {31'b0, $signed(alu_b) <= $signed(alu_a)};
            5'b10011: aluout = {31'b0, alu_b != alu_a};
            default:  aluout = '0;
        endcase
        z = (alufunc[4:2] == 3'b100) ? aluout[0] : (aluout == '0);
    end

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [31:0] cur_pc;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs, rt;
        int          iw, dw;
        logic [31:0] rdata;
        bit          wr;
        logic [3:0]  wa;
        logic [31:0] wd;
        int          lat;
        logic [31:0] pcn;
        bit          alu_chk;
        logic [4:0]  fn;
        bit          alur;
        logic [31:0] a, b;
        bit          mem, dwe;
        logic [31:0] daddr, dwd;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs, input logic [3:0] rt,
                                          input logic [14:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] fn, input logic [3:0] rd,
                                          input logic [3:0] rs, input logic [3:0] rt);
        return {5'b00000, rd, rs, rt, 10'b0, fn};
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] ins,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input int iw, input int dw, input logic [31:0] rdata,
                                input bit wr, input logic [3:0] wa, input logic [31:0] wd,
                                input int lat, input logic [31:0] pcn,
                                input bit alu_chk, input logic [4:0] fn, input bit ar,
                                input logic [31:0] a, input logic [31:0] b,
                                input bit mem, input bit dwe,
                                input logic [31:0] daddr, input logic [31:0] dwd);
        vec_t v;
        v.name = nm; v.instr = ins; v.rs = rs; v.rt = rt; v.iw = iw; v.dw = dw;
        v.rdata = rdata; v.wr = wr; v.wa = wa; v.wd = wd; v.lat = lat; v.pcn = pcn;
        v.alu_chk = alu_chk; v.fn = fn; v.alur = ar; v.a = a; v.b = b;
        v.mem = mem; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset    = 1'b1;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        step(); step(); step();
        chk("rst imem_req",   32'(imem_req),  32'h0);
        chk("rst dmem_req",   32'(dmem_req),  32'h0);
        chk("rst dmem_we",    32'(dmem_we),   32'h0);
        chk("rst reg_we",     32'(reg_we),    32'h0);
        chk("rst pc",         imem_addr,      32'h0);
        chk("rst alufunc",    32'(alufunc),   32'h0);
        chk("rst alur",       32'(alur),      32'h0);
        chk("rst alu_a",      alu_a,          32'h0);
        chk("rst alu_b",      alu_b,          32'h0);
        chk("rst illegal",    32'(illegal),   32'h0);
        chk("rst reg_waddr",  32'(reg_waddr), 32'h0);
        chk("rst reg_wdata",  reg_wdata,      32'h0);
        chk("rst dmem_addr",  dmem_addr,      32'h0);
        chk("rst dmem_wdata", dmem_wdata,     32'h0);
        chk("rst state",      32'(dbg_state), 32'(ST_FETCH));
        reset = 1'b0;
        cur_pc = 32'h0;
        exp_q.delete();
        step();
    endtask

    // Issue one instruction and follow it until the next fetch (or TRAP).
    task automatic run_instr(input vec_t v);
        int cyc, iw, dw, nreq;
        bit done, fetched;
        logic [35:0] e;
        chk({v.name, " start pc"}, imem_addr, cur_pc);
        imem_data  = v.instr;
        rs_data    = v.rs;
        rt_data    = v.rt;
        dmem_rdata = v.rdata;
        if (v.wr) exp_q.push_back({v.wa, v.wd});
        iw = v.iw; dw = v.dw; nreq = 0; cyc = 0; done = 0; fetched = 0;
        while (!done) begin
            cyc++;
            if (imem_req) begin
                imem_rdy = (iw == 0);
                if (iw == 0) fetched = 1; else iw--;
            end else begin
                imem_rdy = 1'b0;
            end
            if (dmem_req) begin
                nreq++;
                chk({v.name, " dmem_addr"}, dmem_addr, v.daddr);
                chk({v.name, " dmem_we"}, 32'(dmem_we), 32'(v.dwe));
                if (v.dwe) chk({v.name, " dmem_wdata"}, dmem_wdata, v.dwd);
                dmem_rdy = (dw == 0);
                if (dw > 0) dw--;
            end else begin
                dmem_rdy = 1'b0;
            end
            if (reg_we) begin
                chk({v.name, " we/req overlap"}, 32'(dmem_req), 32'h0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s unexpected write: got waddr %h wdata %h want none",
                             v.name, reg_waddr, reg_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk({v.name, " waddr"}, 32'(reg_waddr), 32'(e[35:32]));
                    chk({v.name, " wdata"}, reg_wdata, e[31:0]);
                end
            end
            step();
            if ((imem_req && fetched) || dbg_state == ST_TRAP) begin
                done = 1;
            end else if (cyc >= 40) begin
                total++; bad++;
                $display("FAIL %s timeout: got %0d cycles want %0d", v.name, cyc, v.lat);
                done = 1;
            end
        end
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
        chk({v.name, " next pc"}, imem_addr, v.pcn);
        chk({v.name, " rs_addr"}, 32'(rs_addr), 32'(v.instr[22:19]));
        chk({v.name, " mem reqs"}, 32'(nreq), v.mem ? 32'(v.dw + 1) : 32'h0);
        if (v.alu_chk) begin
            chk({v.name, " alufunc"}, 32'(alufunc), 32'(v.fn));
            chk({v.name, " alur"}, 32'(alur), 32'(v.alur));
            chk({v.name, " alu_a"}, alu_a, v.a);
            chk({v.name, " alu_b"}, alu_b, v.b);
        end
        chk({v.name, " pending writes"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        cur_pc = v.pcn;
    endtask

    task automatic reset_mid_mem();
        int n;
        bit hit;
        imem_data = enc_i(5'b01110, 4'd0, 4'd7, 4'd6, 15'd0);
        rs_data   = 32'h300;
        rt_data   = 32'h55;
        n = 0; hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            imem_rdy = imem_req;
            dmem_rdy = 1'b0;
            if (dmem_req) begin
                n++;
                chk("midmem dmem_addr", dmem_addr, 32'h300);
            end
            if (n == 2) begin
                reset = 1'b1;
                hit   = 1;
            end
            step();
        end
        imem_rdy = 1'b0;
        if (!hit) begin
            total++; bad++;
            $display("FAIL midmem timeout: got %0d req cycles want 2", n);
        end else begin
            chk("midmem dmem_req", 32'(dmem_req), 32'h0);
            chk("midmem pc", imem_addr, 32'h0);
            chk("midmem state", 32'(dbg_state), 32'(ST_FETCH));
        end
        reset = 1'b0;
        cur_pc = 32'h0;
        exp_q.delete();
        step();
    endtask

`ifdef ALU_SEQ_CTRL_TRAP_EN
    task automatic trap_seq(input string nm, input logic [31:0] ins);
        logic [31:0] tpc;
        tpc = cur_pc;
        run_instr(mk(nm, ins, 32'h0, 32'h0, 0, 0, 32'h0, 0, 4'd0, 32'h0,
                     2, tpc, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
        chk({nm, " illegal"}, 32'(illegal), 32'h1);
        for (int i = 0; i < 4; i++) begin
            imem_rdy = 1'b1;
            dmem_rdy = 1'b1;
            step();
            chk({nm, " hold imem_req"}, 32'(imem_req), 32'h0);
            chk({nm, " hold dmem_req"}, 32'(dmem_req), 32'h0);
            chk({nm, " hold reg_we"}, 32'(reg_we), 32'h0);
            chk({nm, " hold pc"}, imem_addr, tpc);
        end
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        chk({nm, " sticky"}, 32'(illegal), 32'h1);
        do_reset();
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; imem_rdy = 1'b0; dmem_rdy = 1'b0;
        imem_data = '0; rs_data = '0; rt_data = '0; dmem_rdata = '0;
        cur_pc = 32'h0;

        vt[0]  = mk("addi", enc_i(5'b11000, 4'd1, 4'd0, 4'd0, 15'd5), 32'h0, 32'h0, 0, 0, 32'h0,
                    1, 4'd1, 32'h5, 4, 32'h4, 1, 5'b11000, 0, 32'h0, 32'h5, 0, 0, 32'h0, 32'h0);
        vt[1]  = mk("sub", enc_r(5'b01000, 4'd3, 4'd1, 4'd2), 32'd9, 32'd12, 0, 0, 32'h0,
                    1, 4'd3, 32'hFFFFFFFD, 4, 32'h8, 1, 5'b01000, 1, 32'd9, 32'd12, 0, 0, 32'h0, 32'h0);
        vt[2]  = mk("xor", enc_r(5'b11110, 4'd4, 4'd1, 4'd2), 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h0,
                    1, 4'd4, 32'h0FF00FF0, 4, 32'hC, 1, 5'b11110, 1, 32'hF0F0F0F0, 32'hFF00FF00,
                    0, 0, 32'h0, 32'h0);
        vt[3]  = mk("ori fetch wait", enc_i(5'b11101, 4'd7, 4'd1, 4'd0, 15'h7FFF), 32'h1234, 32'h0,
                    1, 0, 32'h0, 1, 4'd7, 32'hFFFFFFFF, 5, 32'h10, 1, 5'b11101, 0, 32'h1234,
                    32'hFFFFFFFF, 0, 0, 32'h0, 32'h0);
        vt[4]  = mk("jal", enc_i(5'b10111, 4'd15, 4'd1, 4'd0, 15'd4), 32'h200, 32'h0, 0, 0, 32'h0,
                    1, 4'd15, 32'h14, 3, 32'h210, 1, 5'b10111, 0, 32'h200, 32'h10, 0, 0, 32'h0, 32'h0);
        vt[5]  = mk("jal r0", enc_i(5'b10111, 4'd0, 4'd1, 4'd0, 15'd0), 32'h40, 32'h0, 0, 0, 32'h0,
                    1, 4'd0, 32'h214, 3, 32'h40, 1, 5'b10111, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
        vt[6]  = mk("blt taken", enc_i(5'b10001, 4'd0, 4'd1, 4'd2, 15'h7FFE), 32'd3, 32'd7, 0, 0, 32'h0,
                    0, 4'd0, 32'h0, 3, 32'h3C, 1, 5'b10001, 0, 32'd7, 32'd3, 0, 0, 32'h0, 32'h0);
        vt[7]  = mk("beq taken", enc_i(5'b10000, 4'd0, 4'd1, 4'd2, 15'd1), 32'd5, 32'd5, 0, 0, 32'h0,
                    0, 4'd0, 32'h0, 3, 32'h44, 1, 5'b10000, 0, 32'd5, 32'd5, 0, 0, 32'h0, 32'h0);
        vt[8]  = mk("blt not taken", enc_i(5'b10001, 4'd0, 4'd1, 4'd2, 15'h7FFE), 32'd7, 32'd7, 0, 0,
                    32'h0, 0, 4'd0, 32'h0, 3, 32'h48, 1, 5'b10001, 0, 32'd7, 32'd7, 0, 0, 32'h0, 32'h0);
        vt[9]  = mk("lw wait2", enc_i(5'b01010, 4'd5, 4'd2, 4'd0, 15'd8), 32'h100, 32'h0, 0, 2,
                    32'hDEADBEEF, 1, 4'd5, 32'hDEADBEEF, 7, 32'h4C, 1, 5'b01010, 0, 32'h100, 32'h8,
                    1, 0, 32'h108, 32'h0);
        vt[10] = mk("sw", enc_i(5'b01110, 4'd0, 4'd7, 4'd6, 15'h7FFC), 32'h300, 32'hCAFE0000, 0, 0,
                    32'h0, 0, 4'd0, 32'h0, 4, 32'h50, 1, 5'b01110, 0, 32'h300, 32'hFFFFFFFC,
                    1, 1, 32'h2FC, 32'hCAFE0000);
        vt[11] = mk("jal to top", enc_i(5'b10111, 4'd0, 4'd1, 4'd0, 15'd0), 32'hFFFFFFFC, 32'h0, 0, 0,
                    32'h0, 1, 4'd0, 32'h54, 3, 32'hFFFFFFFC, 1, 5'b10111, 0, 32'hFFFFFFFC, 32'h0,
                    0, 0, 32'h0, 32'h0);
        vt[12] = mk("addi pc wrap", enc_i(5'b11000, 4'd2, 4'd0, 4'd0, 15'h7FFF), 32'h0, 32'h0, 0, 0,
                    32'h0, 1, 4'd2, 32'hFFFFFFFF, 4, 32'h0, 1, 5'b11000, 0, 32'h0, 32'hFFFFFFFF,
                    0, 0, 32'h0, 32'h0);
        vt[13] = mk("ne", enc_r(5'b10011, 4'd8, 4'd1, 4'd2), 32'd5, 32'd6, 0, 0, 32'h0,
                    1, 4'd8, 32'h1, 4, 32'h4, 1, 5'b10011, 1, 32'd5, 32'd6, 0, 0, 32'h0, 32'h0);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) run_instr(vt[i]);

`ifdef ALU_SEQ_CTRL_TRAP_EN
        trap_seq("trap op", enc_i(5'b00111, 4'd1, 4'd2, 4'd3, 15'd0));
        trap_seq("trap fn", enc_r(5'b00001, 4'd1, 4'd2, 4'd3));
`else
        run_instr(mk("nop op", enc_i(5'b00111, 4'd1, 4'd2, 4'd3, 15'd0), 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 4'd0, 32'h0, 2, cur_pc + 32'h4, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
        chk("nop op illegal", 32'(illegal), 32'h0);
        run_instr(mk("nop fn", enc_r(5'b00001, 4'd1, 4'd2, 4'd3), 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 4'd0, 32'h0, 2, cur_pc + 32'h4, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
        chk("nop fn illegal", 32'(illegal), 32'h0);
`endif

        reset_mid_mem();
        run_instr(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencing controller that drives the ALU: fetches a 32-bit instruction, decodes it into the ALU's `ALUFUNC`/`ALUR` encoding, and registers the operands onto `A`/`B`. It then consumes `ALUOUT`/`Z` to perform register writeback, data-memory access, branch and JAL PC updates. It sits between the instruction/data memories and register file on one side and the ALU on the other, replacing hard-wired single-cycle control.

## Interface
- `DBITS`, 32, datapath width
- `OPCODEBITS`, 5, width of `ALUFUNC`
- `RESETPC`, 32'h0, PC value after reset
- `CLK` in 1, sole clock, rising edge
- `RESET` in 1, synchronous, active-high
- `IMEM_ADDR` out DBITS, fetch address (= PC)
- `IMEM_REQ` out 1, fetch request; `IMEM_RDY` in 1, `IMEM_DATA` in 32
- `RS_ADDR`, `RT_ADDR` out 4, register-file read addresses (combinational from IR); `RS_DATA`, `RT_DATA` in DBITS
- `ALUFUNC` out OPCODEBITS, `ALUR` out 1, `ALU_A`, `ALU_B` out DBITS (all registered)
- `ALUOUT` in DBITS, `Z` in 1, from ALU (combinational)
- `REG_WE` out 1, `REG_WADDR` out 4, `REG_WDATA` out DBITS
- `DMEM_REQ` out 1, `DMEM_WE` out 1, `DMEM_ADDR` out DBITS, `DMEM_WDATA` out DBITS; `DMEM_RDY` in 1, `DMEM_RDATA` in DBITS
- `ILLEGAL` out 1, sticky illegal-instruction flag

## Operation
- IR fields: OP=IR[31:27], RD=IR[26:23], RS=IR[22:19], RT=IR[18:15], FN=IR[4:0], IMM=sign-extend(IR[14:0]) to DBITS.
- OP=5'b00000 is the register class: `ALUR`=1, `ALUFUNC`=FN. Legal FN values: ADD 11000, SUB 01000, AND 11100, OR 11101, XOR 11110, NAND 01100, NOR 01101, NXOR 01110, EQ 10000, LT 10001, LE 10010, NE 10011.
- All other OPs: `ALUR`=0, `ALUFUNC`=OP. Legal OPs: ADDI 11000, ANDI 11100, ORI 11101, XORI 11110, LW 01010, SW 01110, BEQ 10000, BLT 10001, BLE 10010, BNE 10011, JAL 10111.
- Operands latched in DECODE:
  - Register class: A=RS_DATA, B=RT_DATA.
  - Immediate ALU ops, LW, SW: A=RS_DATA, B=IMM.
  - Branches: A=RT_DATA, B=RS_DATA, so ALU Z = (RS op RT).
  - JAL: A=RS_DATA, B=IMM<<2.
- States:
  - FETCH: `IMEM_REQ`=1 until `IMEM_RDY`; on RDY latch IR and go to DECODE.
  - DECODE: latch operands, `ALUFUNC`, `ALUR`, and SW store data (RT_DATA); go to EXEC, or to TRAP if illegal.
  - EXEC: ALU result valid.
    - Register/immediate ALU ops: latch ALUOUT, go to WB.
    - LW/SW: latch ALUOUT as `DMEM_ADDR`, go to MEM.
    - Branch: PC = Z ? PC+4+(IMM<<2) : PC+4; go to FETCH.
    - JAL: RD←PC+4, PC=ALUOUT; go to FETCH.
  - MEM: `DMEM_REQ`=1 (`DMEM_WE`=1 for SW) until `DMEM_RDY`. SW then sets PC+=4 and goes to FETCH; LW latches `DMEM_RDATA` and goes to WB.
  - WB: `REG_WE`=1 for exactly one cycle, RD←result, PC+=4, go to FETCH.
  - TRAP: see Configuration.
- Writes to RD=0 still pulse `REG_WE`; the register file ignores r0.
- PC arithmetic is modulo 2^DBITS; wrap from 32'hFFFFFFFC to 0 is silent.

## Timing
- Reset (synchronous) values: state FETCH, PC=RESETPC, IR=0, `ALUFUNC`=0, `ALUR`=0, `ALU_A`=`ALU_B`=0, all REQ/WE outputs 0, `ILLEGAL`=0, `REG_WADDR`=0, `REG_WDATA`=0, `DMEM_ADDR`=`DMEM_WDATA`=0.
- `RESET` in any state, including mid-MEM with REQ high, aborts in the same edge; REQ drops the next cycle.
- Latency with zero-wait memories (RDY high in the first REQ cycle): branch 3 cycles, JAL 3, ALU ops 4, SW 4, LW 5. Each RDY-low cycle adds one.
- REQ is held stable, with address and data unchanged, until the RDY cycle. RDY is ignored while REQ=0.
- `REG_WE` and `DMEM_REQ` are never high in the same cycle.

## Configuration
- `ALU_SEQ_CTRL_TRAP_EN` defined: an illegal OP/FN in DECODE enters TRAP. TRAP sets `ILLEGAL`=1, holds PC at the faulting instruction, issues no REQ/WE, and exits only on `RESET`.
- Not defined: illegal instructions execute as NOP (DECODE→FETCH, PC+=4, 2 cycles) and `ILLEGAL` is tied to 0.

## Test plan
- Reset, then ADDI r1,r0,5 with RS_DATA=0 → `ALUR`=0, `ALUFUNC`=11000, `ALU_B`=5, `REG_WE` pulse with WADDR=1 and WDATA=5 in cycle 4, PC=4.
- SUB r3,r1,r2 with RS=9, RT=12 → `ALUR`=1, `ALUFUNC`=01000, WDATA=32'hFFFFFFFD.
- BLT, IMM=-2, RS=3, RT=7, at PC=0x40 → Z=1, PC=0x3C after 3 cycles. With RS=7: PC=0x44.
- LW r5,8(r2) with RS=0x100 and DMEM_RDY delayed 2 cycles → `DMEM_ADDR`=0x108 held stable for 3 REQ cycles, r5←DMEM_RDATA, total 7 cycles.
- JAL r15,IMM=4 with RS=0x200 at PC=0x10 → r15←0x14, PC=0x210.
- OP=5'b00111, with and without `ALU_SEQ_CTRL_TRAP_EN` → TRAP with `ILLEGAL`=1 and PC frozen; otherwise NOP with PC+=4. Then `RESET` mid-MEM of a SW → `DMEM_REQ` low the next cycle, PC=RESETPC.
